// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU sharing arbiter.
// Imported by the arbiter top and its round-robin picker.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

    localparam int ALU_CTRL_W   = 3;
    localparam int ALU_SEL_W    = 2;
    localparam int XLEN_DEFAULT = 32;

    // Index width for a requester count, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr.
// The pointer itself lives in the caller.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int idx;

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, one op at a time.
// Issue registers feed the ALU; its outputs are held as a response.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*XLEN-1:0]         req_op_a,
    input  logic [NUM_REQ*XLEN-1:0]         req_op_b,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0]   req_alu_control,
    input  logic [NUM_REQ*ALU_SEL_W-1:0]    req_alu_sel,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [XLEN-1:0]                 rsp_result,
    output logic                            rsp_zero_flag,
    output logic                            rsp_bt,
    output logic                            busy,
    output logic [XLEN-1:0]                 alu_read_data1,
    output logic [XLEN-1:0]                 alu_read_data2,
    output logic [ALU_CTRL_W-1:0]           alu_alu_control,
    output logic [ALU_SEL_W-1:0]            alu_alu_sel,
    input  logic [XLEN-1:0]                 alu_result,
    input  logic                            alu_zero_flag,
    input  logic                            alu_bt
);

    localparam int IW = idx_w(NUM_REQ);

    alu_arb_state_t       state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        grant_idx;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 accept;
    logic                 rsp_done;
    logic [IW-1:0]        ptr_next;

    logic [XLEN-1:0]       op_a [NUM_REQ];
    logic [XLEN-1:0]       op_b [NUM_REQ];
    logic [ALU_CTRL_W-1:0] op_c [NUM_REQ];
    logic [ALU_SEL_W-1:0]  op_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i] = req_op_a[i*XLEN +: XLEN];
        assign op_b[i] = req_op_b[i*XLEN +: XLEN];
        assign op_c[i] = req_alu_control[i*ALU_CTRL_W +: ALU_CTRL_W];
        assign op_s[i] = req_alu_sel[i*ALU_SEL_W +: ALU_SEL_W];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gating on reset keeps every ready low while reset is held.
    assign req_ready = (reset && state == IDLE) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP) ? grant_oh : '0;
    assign rsp_done  = (state == RESP) && |(rsp_ready & grant_oh);
    assign busy      = (state != IDLE);

    assign ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0
                                                      : grant_idx + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant_idx       <= '0;
            grant_oh        <= '0;
            alu_read_data1  <= '0;
            alu_read_data2  <= '0;
            alu_alu_control <= '0;
            alu_alu_sel     <= '0;
            rsp_result      <= '0;
            rsp_zero_flag   <= 1'b0;
            rsp_bt          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant_idx       <= gnt_idx;
                        grant_oh        <= gnt;
                        alu_read_data1  <= op_a[gnt_idx];
                        alu_read_data2  <= op_b[gnt_idx];
                        alu_alu_control <= op_c[gnt_idx];
                        alu_alu_sel     <= op_s[gnt_idx];
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result    <= alu_result;
                    rsp_zero_flag <= alu_zero_flag;
                    rsp_bt        <= alu_bt;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rr_ptr <= ptr_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_alu_arbiter;

    localparam int XLEN = 32;
    localparam int N    = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*XLEN-1:0] req_op_a = '0;
    logic [N*XLEN-1:0] req_op_b = '0;
    logic [N*3-1:0]  req_alu_control = '0;
    logic [N*2-1:0]  req_alu_sel = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero_flag;
    logic            rsp_bt;
    logic            busy;
    logic [XLEN-1:0] alu_read_data1;
    logic [XLEN-1:0] alu_read_data2;
    logic [2:0]      alu_alu_control;
    logic [1:0]      alu_alu_sel;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero_flag;
    logic            alu_bt;

    always #5 clk = ~clk;

    assign alu_result    = alu_read_data1 + alu_read_data2;
    assign alu_zero_flag = (alu_result == '0);
    assign alu_bt        = (alu_read_data1 == alu_read_data2);

    alu_arbiter #(.XLEN(XLEN), .NUM_REQ(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op_a        (req_op_a),
        .req_op_b        (req_op_b),
        .req_alu_control (req_alu_control),
        .req_alu_sel     (req_alu_sel),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_zero_flag   (rsp_zero_flag),
        .rsp_bt          (rsp_bt),
        .busy            (busy),
        .alu_read_data1  (alu_read_data1),
        .alu_read_data2  (alu_read_data2),
        .alu_alu_control (alu_alu_control),
        .alu_alu_sel     (alu_alu_sel),
        .alu_result      (alu_result),
        .alu_zero_flag   (alu_zero_flag),
        .alu_bt          (alu_bt)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [N-1:0] pick(input logic [N-1:0] v,
                                          input int p);
        logic [N-1:0] one;
        int i;
        one = 1;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (v[i]) return one << i;
        end
        return '0;
    endfunction

    // Transaction model: an op is accepted, spends one cycle executing,
    // then is offered to its requester until accepted.
    bit              m_act;
    int              m_age;
    int              m_idx;
    int              m_ptr;
    logic [XLEN-1:0] m_a, m_b, m_sum;
    logic [2:0]      m_c;
    logic [1:0]      m_s;
    logic [N-1:0]    m_exp;
    logic [N-1:0]    m_one;

    always @(negedge clk) begin
        m_one = 1;
        if (!reset) begin
            m_act = 0; m_age = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_c = '0; m_s = '0;
            chk("m_rst_ready", req_ready, 0);
            chk("m_rst_rsp_valid", rsp_valid, 0);
            chk("m_rst_busy", busy, 0);
        end else begin
            chk("m_alu_a", alu_read_data1, m_a);
            chk("m_alu_b", alu_read_data2, m_b);
            chk("m_alu_ctl", alu_alu_control, m_c);
            chk("m_alu_sel", alu_alu_sel, m_s);
            if (!m_act) begin
                m_exp = pick(req_valid, m_ptr);
                chk("m_idle_ready", req_ready, m_exp);
                chk("m_idle_busy", busy, 0);
                chk("m_idle_rsp_valid", rsp_valid, 0);
                if (m_exp != '0) begin
                    for (int i = 0; i < N; i++)
                        if (m_exp[i]) m_idx = i;
                    m_act = 1; m_age = 1;
                    m_a = req_op_a[m_idx*XLEN +: XLEN];
                    m_b = req_op_b[m_idx*XLEN +: XLEN];
                    m_c = req_alu_control[m_idx*3 +: 3];
                    m_s = req_alu_sel[m_idx*2 +: 2];
                end
            end else if (m_age == 1) begin
                chk("m_exec_busy", busy, 1);
                chk("m_exec_ready", req_ready, 0);
                chk("m_exec_rsp_valid", rsp_valid, 0);
                m_age = 2;
            end else begin
                m_sum = m_a + m_b;
                chk("m_rsp_valid", rsp_valid, m_one << m_idx);
                chk("m_rsp_busy", busy, 1);
                chk("m_rsp_ready_out", req_ready, 0);
                chk("m_rsp_result", rsp_result, m_sum);
                chk("m_rsp_zero", rsp_zero_flag, m_sum == 0);
                chk("m_rsp_bt", rsp_bt, m_a == m_b);
                if (rsp_ready[m_idx]) begin
                    m_act = 0;
                    m_ptr = (m_idx + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] c,
                          input logic [1:0] s);
        req_op_a[r*XLEN +: XLEN] = a;
        req_op_b[r*XLEN +: XLEN] = b;
        req_alu_control[r*3 +: 3] = c;
        req_alu_sel[r*2 +: 2] = s;
    endtask

    task automatic wait_ready(input logic [N-1:0] want, input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready == want) break;
        end
        chk(nm, req_ready, want);
    endtask

    task automatic wait_rsp(input logic [N-1:0] want, input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid == want) break;
        end
        chk(nm, rsp_valid, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests pending during reset
        req_valid = 2'b11;
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_read_data1, 0);
        chk("rst_rsp_result", rsp_result, 0);
        req_valid = '0;
        step();
        step();
        reset = 1'b1;

        // 1: single request
        rsp_ready = 2'b11;
        set_op(0, 5, 7, 3'b000, 2'b00);
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_exec_a", alu_read_data1, 5);
        chk("t1_exec_b", alu_read_data2, 7);
        chk("t1_exec_ctl", alu_alu_control, 0);
        chk("t1_exec_sel", alu_alu_sel, 0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_result", rsp_result, 12);
        chk("t1_zero", rsp_zero_flag, 0);
        chk("t1_bt", rsp_bt, 0);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);

        // 2: contention after a fresh reset
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_op(0, 1, 2, 3'b001, 2'b00);
        set_op(1, 10, 20, 3'b010, 2'b01);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ready((g % 2 == 0) ? 2'b01 : 2'b10, "t2_grant");
            wait_rsp((g % 2 == 0) ? 2'b01 : 2'b10, "t2_rsp_valid");
            chk("t2_result", rsp_result, (g % 2 == 0) ? 3 : 30);
        end
        step();
        req_valid = '0;

        // 3: backpressure on requester 1
        rsp_ready = 2'b00;
        set_op(1, 32'h10, 32'h10, 3'b010, 2'b01);
        req_valid = 2'b10;
        wait_ready(2'b10, "t3_grant");
        step();
        req_valid = '0;
        wait_rsp(2'b10, "t3_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", rsp_valid, 2'b10);
            chk("t3_hold_result", rsp_result, 32'h20);
            chk("t3_hold_bt", rsp_bt, 1);
            chk("t3_hold_ready", req_ready, 0);
            chk("t3_hold_busy", busy, 1);
            @(negedge clk);
        end
        step();
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("t3_wrong_idx", rsp_valid, 2'b10);
        step();
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("t3_last_resp", rsp_valid, 2'b10);
        @(negedge clk);
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_valid", rsp_valid, 0);

        // 4: zero result, odd control/select pass through
        step();
        rsp_ready = 2'b11;
        set_op(0, 32'hFFFF_FFFF, 1, 3'b101, 2'b10);
        req_valid = 2'b01;
        wait_ready(2'b01, "t4_grant");
        step();
        req_valid = '0;
        wait_rsp(2'b01, "t4_rsp_valid");
        chk("t4_result", rsp_result, 0);
        chk("t4_zero", rsp_zero_flag, 1);
        chk("t4_bt", rsp_bt, 0);

        // 5: reset during EXEC
        step();
        set_op(0, 3, 4, 3'b011, 2'b11);
        set_op(1, 6, 6, 3'b001, 2'b00);
        req_valid = 2'b01;
        wait_ready(2'b01, "t5_grant");
        @(posedge clk);
        #2;
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", rsp_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_alu_a", alu_read_data1, 0);
        chk("t5_rst_alu_ctl", alu_alu_control, 0);
        chk("t5_rst_zero", rsp_zero_flag, 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_rsp", rsp_valid, 0);
        end
        step();
        req_valid = 2'b11;
        wait_ready(2'b01, "t5_ptr_zero");
        step();
        req_valid = '0;
        wait_rsp(2'b01, "t5_rsp_valid");
        chk("t5_result", rsp_result, 7);

        // 6: request withdrawn while another op is in RESP
        step();
        rsp_ready = 2'b00;
        set_op(1, 2, 9, 3'b000, 2'b00);
        req_valid = 2'b10;
        wait_ready(2'b10, "t6_grant");
        step();
        req_valid = '0;
        wait_rsp(2'b10, "t6_rsp_valid");
        step();
        req_valid = 2'b01;
        @(negedge clk);
        chk("t6_no_ready_resp", req_ready, 0);
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("t6_idle_ready", req_ready, 0);
        chk("t6_idle_busy", busy, 0);
        @(negedge clk);
        chk("t6_still_idle", busy, 0);

        step();
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
